// File: rtl/com_n.sv
// com_n: UART register link. Receives a frame of NUM_REGS bytes and loads all
// of them into DATA_IN at once. It then replies with a snapshot of DATA_OUT.
// At most one reply can be held pending while another reply is on the line.
module com_n #(
  parameter int unsigned CLK_HZ       = 12000000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned NUM_REGS     = 2,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  RX,
  output logic                  TX,
  output logic [8*NUM_REGS-1:0] DATA_IN,
  input  logic [8*NUM_REGS-1:0] DATA_OUT,
  output logic                  UPDATE,
  output logic                  BUSY
);

  localparam int unsigned CPB    = CLK_HZ / BAUD;
  localparam int unsigned HALF   = CPB / 2;
  localparam int unsigned CW     = $clog2(CPB);
  localparam int unsigned IW     = $clog2(NUM_REGS + 1);
  localparam int unsigned BW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned TO_MAX = TIMEOUT_BITS * CPB;
  localparam int unsigned TW     = $clog2(TO_MAX + 1);
  localparam int unsigned DW     = 8 * NUM_REGS;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_NEXT} tx_state_t;

  logic            rx_meta_q, rx_sync_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [IW-1:0]   rx_idx_q, rx_idx_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [DW-1:0]   data_in_q, data_in_d;
  logic            update_q, update_d;

  tx_state_t       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [BW-1:0]   tx_byte_q, tx_byte_d;
  logic [DW-1:0]   txbuf_q, txbuf_d;
  logic            pend_q, pend_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;

  logic frame_done;
  logic last_byte;

  assign frame_done = (rx_idx_q == IW'(NUM_REGS));
  assign last_byte  = (tx_byte_q == BW'(NUM_REGS - 1));

  assign TX      = tx_q;
  assign BUSY    = busy_q;
  assign DATA_IN = data_in_q;
  assign UPDATE  = update_q;

  // Two-flop synchroniser for the asynchronous RX line.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX deframer, shadow bank, inter-byte timeout and frame commit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_idx_d   = rx_idx_q;
    shadow_d   = shadow_q;
    to_cnt_d   = '0;
    data_in_d  = data_in_q;
    update_d   = 1'b0;

    if (frame_done) begin
      data_in_d = shadow_q;
      update_d  = 1'b1;
      rx_idx_d  = '0;
    end

    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end else if (rx_idx_q != '0 && !frame_done) begin
          if (to_cnt_q == TW'(TO_MAX - 1)) begin
            rx_idx_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      RX_START: begin
        if (rx_cnt_q == CW'(HALF - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CW'(CPB - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CW'(CPB - 1)) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
              if (rx_idx_q == IW'(k)) shadow_d[8*k +: 8] = rx_shift_q;
            end
            rx_idx_d   = rx_idx_q + 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_idx_d   = '0;
            rx_state_d = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state and register bank.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_idx_q   <= '0;
      shadow_q   <= '0;
      to_cnt_q   <= '0;
      data_in_q  <= '0;
      update_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_idx_q   <= rx_idx_d;
      shadow_q   <= shadow_d;
      to_cnt_q   <= to_cnt_d;
      data_in_q  <= data_in_d;
      update_q   <= update_d;
    end
  end

  // TX serialiser with a single pending-reply slot. The stop bit is split
  // into STOP (CPB-1 cycles) and NEXT (1 cycle), so that bytes and replies
  // follow each other without an idle gap on the line.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    txbuf_d    = txbuf_q;
    pend_d     = pend_q;

    case (tx_state_q)
      TX_IDLE: begin
        if (frame_done) begin
          txbuf_d    = DATA_OUT;
          tx_byte_d  = '0;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CW'(CPB - 1)) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CW'(CPB - 1)) begin
          tx_cnt_d = '0;
          txbuf_d  = txbuf_q >> 1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CW'(CPB - 2)) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_NEXT;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_NEXT: begin
        tx_cnt_d = '0;
        if (!last_byte) begin
          tx_byte_d  = tx_byte_q + 1'b1;
          tx_state_d = TX_START;
        end else if (pend_q || frame_done) begin
          txbuf_d    = DATA_OUT;
          tx_byte_d  = '0;
          tx_state_d = TX_START;
          pend_d     = pend_q && frame_done;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (frame_done && tx_state_q != TX_IDLE && !(tx_state_q == TX_NEXT && last_byte)) begin
      pend_d = 1'b1;
    end

    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = txbuf_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (tx_state_d != TX_IDLE);
  end

  // TX state and registered line/busy outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      txbuf_q    <= '0;
      pend_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      txbuf_q    <= txbuf_d;
      pend_q     <= pend_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_com_n.sv
// Testbench for com_n. Uses 12 clocks per bit, NUM_REGS=2 and a 20-bit timeout.
module tb_com_n;

  localparam int CPB = 12;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b1;
  logic        RX    = 1'b1;
  logic        TX;
  logic [15:0] DATA_IN;
  logic [15:0] DATA_OUT = 16'h1234;
  logic        UPDATE;
  logic        BUSY;

  com_n #(
    .CLK_HZ(12000000),
    .BAUD(1000000),
    .NUM_REGS(2),
    .TIMEOUT_BITS(20)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .RX(RX),
    .TX(TX),
    .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT),
    .UPDATE(UPDATE),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int          checks   = 0;
  int          failures = 0;
  int unsigned upd_count = 0;

  // Model: frames expected to commit, reply bytes expected on TX, and the
  // expected length of each BUSY window.
  logic [15:0] exp_frames[$];
  logic [7:0]  exp_bytes[$];
  int          exp_busy[$];
  logic [15:0] m_data_in = '0;

  bit          dec_active = 0;
  int          dec_cnt    = 0;
  logic [7:0]  dec_shift  = '0;
  bit          upd_prev   = 0;
  bit          busy_prev  = 0;
  int          busy_run   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  // Compare process: on each falling edge, checks DUT outputs against the model.
  always @(negedge CLK) begin
    if (!RST_N) begin
      dec_active = 0;
      busy_run   = 0;
      upd_prev   = 0;
      busy_prev  = 0;
      exp_frames.delete();
      exp_bytes.delete();
      exp_busy.delete();
      m_data_in = '0;
      check("rst_tx", TX, 1'b1);
      check("rst_busy", BUSY, 1'b0);
      check("rst_update", UPDATE, 1'b0);
      check("rst_data_in", DATA_IN, 16'h0000);
    end else begin
      if (UPDATE) begin
        upd_count++;
        check("update_single_cycle", upd_prev, 1'b0);
        if (exp_frames.size() == 0) unexpected("update_unexpected", DATA_IN);
        else m_data_in = exp_frames.pop_front();
      end
      check("data_in", DATA_IN, m_data_in);

      if (BUSY && !busy_prev) check("busy_rise_with_update", UPDATE, 1'b1);
      if (BUSY) busy_run++;
      if (!BUSY && busy_prev) begin
        if (exp_busy.size() == 0) unexpected("busy_window_unexpected", busy_run);
        else check("busy_cycles", busy_run, exp_busy.pop_front());
        busy_run = 0;
      end
      if (!BUSY) check("tx_idle_high", TX, 1'b1);

      if (!dec_active) begin
        if (TX == 1'b0) begin
          dec_active = 1;
          dec_cnt    = 0;
        end
      end else begin
        dec_cnt++;
        if (dec_cnt == 6) begin
          check("tx_start_bit", TX, 1'b0);
        end else if (dec_cnt > 6 && dec_cnt < 114 && (dec_cnt - 6) % 12 == 0) begin
          dec_shift = {TX, dec_shift[7:1]};
        end else if (dec_cnt == 114) begin
          check("tx_stop_bit", TX, 1'b1);
          if (exp_bytes.size() == 0) unexpected("tx_byte_unexpected", dec_shift);
          else check("tx_byte", dec_shift, exp_bytes.pop_front());
          dec_active = 0;
        end
      end
      upd_prev  = UPDATE;
      busy_prev = BUSY;
    end
  end

  // Sends one byte, starting one time unit after a rising edge. The stop bit
  // lasts stop_cyc clocks.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_cyc);
    RX = 1'b0;
    repeat (CPB) @(posedge CLK);
    #1;
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(posedge CLK);
      #1;
    end
    RX = stop;
    repeat (stop_cyc) @(posedge CLK);
    #1;
    RX = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Waits until the model has drained and TX is idle, with a cycle budget.
  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((BUSY || dec_active || exp_bytes.size() != 0 || exp_frames.size() != 0 ||
            exp_busy.size() != 0) && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check(name, n < budget, 1'b1);
  endtask

  int unsigned u0;

  initial begin
    // 1: reset held while RX toggles
    #2 RST_N = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK);
      #1 RX = ~RX;
    end
    RX = 1'b1;
    check("t1_tx", TX, 1'b1);
    check("t1_data_in", DATA_IN, 16'h0000);
    check("t1_update", UPDATE, 1'b0);
    check("t1_busy", BUSY, 1'b0);
    idle(1);
    RST_N = 1'b1;
    idle(5);

    // 2: basic frame
    u0 = upd_count;
    exp_frames.push_back(16'h3CA5);
    exp_bytes.push_back(8'h34);
    exp_bytes.push_back(8'h12);
    exp_busy.push_back(240);
    send_byte(8'hA5, 1'b1, CPB);
    send_byte(8'h3C, 1'b1, CPB);
    wait_quiet("t2_drained", 2000);
    check("t2_data_in", DATA_IN, 16'h3CA5);
    check("t2_updates", upd_count - u0, 1);
    idle(20);

    // 3: inter-byte timeout drops the partial frame
    u0 = upd_count;
    exp_frames.push_back(16'h3322);
    exp_bytes.push_back(8'h34);
    exp_bytes.push_back(8'h12);
    exp_busy.push_back(240);
    send_byte(8'h11, 1'b1, CPB);
    idle(25 * CPB);
    send_byte(8'h22, 1'b1, CPB);
    send_byte(8'h33, 1'b1, CPB);
    wait_quiet("t3_drained", 2000);
    check("t3_data_in", DATA_IN, 16'h3322);
    check("t3_updates", upd_count - u0, 1);
    idle(20);

    // 4: framing error discards the byte
    u0 = upd_count;
    exp_frames.push_back(16'h7766);
    exp_bytes.push_back(8'h34);
    exp_bytes.push_back(8'h12);
    exp_busy.push_back(240);
    send_byte(8'h55, 1'b0, CPB);
    idle(24);
    send_byte(8'h66, 1'b1, CPB);
    send_byte(8'h77, 1'b1, CPB);
    wait_quiet("t4_drained", 2000);
    check("t4_data_in", DATA_IN, 16'h7766);
    check("t4_updates", upd_count - u0, 1);
    idle(20);

    // 5: two back-to-back frames; the second reply waits in the pending slot
    u0 = upd_count;
    exp_frames.push_back(16'hD2C1);
    exp_frames.push_back(16'hF4E3);
    exp_bytes.push_back(8'h34);
    exp_bytes.push_back(8'h12);
    exp_bytes.push_back(8'hEF);
    exp_bytes.push_back(8'hBE);
    exp_busy.push_back(480);
    send_byte(8'hC1, 1'b1, 10);
    send_byte(8'hD2, 1'b1, 10);
    fork
      begin
        send_byte(8'hE3, 1'b1, 10);
        send_byte(8'hF4, 1'b1, 10);
      end
      begin
        idle(40);
        DATA_OUT = 16'hBEEF;
      end
    join
    wait_quiet("t5_drained", 3000);
    check("t5_data_in", DATA_IN, 16'hF4E3);
    check("t5_updates", upd_count - u0, 2);
    idle(20);

    // 6: a 3-cycle glitch is rejected, then reset is asserted in the middle of a reply
    u0 = upd_count;
    RX = 1'b0;
    idle(3);
    RX = 1'b1;
    idle(60);
    check("t6_glitch_no_update", upd_count - u0, 0);
    exp_frames.push_back(16'h8B9A);
    exp_bytes.push_back(8'hEF);
    exp_bytes.push_back(8'hBE);
    exp_busy.push_back(240);
    send_byte(8'h9A, 1'b1, CPB);
    send_byte(8'h8B, 1'b1, CPB);
    check("t6_data_in", DATA_IN, 16'h8B9A);
    check("t6_updates", upd_count - u0, 1);
    idle(125);
    check("t6_first_byte_seen", exp_bytes.size(), 1);
    check("t6_busy_mid_reply", BUSY, 1'b1);
    #1 RST_N = 1'b0;
    #1;
    check("t6_async_tx", TX, 1'b1);
    check("t6_async_busy", BUSY, 1'b0);
    check("t6_async_data_in", DATA_IN, 16'h0000);
    check("t6_async_update", UPDATE, 1'b0);
    idle(3);
    RST_N = 1'b1;
    idle(20);
    check("t6_post_tx", TX, 1'b1);
    check("t6_post_busy", BUSY, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
